// File: rtl/fir_tap_accumulator.sv
// ---------------------------------------------------------------------------
// fir_tap_accumulator
//   Sequential accumulator stage of a direct-form FIR datapath. It sums
//   N_TAPS signed 16-bit partial products per output sample through a single
//   Han-Carlson prefix adder, feeding the running sum back as operand a. Each
//   completed sample is held in a register until the next cascade section
//   takes it.
//
//   Optional feature macro: FIR_ACC_SAT_EN
//     defined   : signed overflow on any accumulate step clamps to
//                 16'h7FFF / 16'h8000, and out_sat flags the sample (sticky
//                 per sample).
//     undefined : arithmetic wraps modulo 2**16 and out_sat is constant 0.
//
//   Ports
//     clk        in   1   rising-edge clock
//     rst        in   1   asynchronous, active-high reset
//     in_valid   in   1   in_data carries a partial product
//     in_ready   out  1   stage accepts a term (transfer on in_valid & in_ready)
//     in_data    in   16  signed partial product
//     out_valid  out  1   out_sum holds a completed sample
//     out_ready  in   1   consumer takes the sample (transfer on out_valid & out_ready)
//     out_sum    out  16  signed accumulated sample
//     out_sat    out  1   saturation occurred in this sample
//
//   Handshake: a word moves across an interface on every rising clk edge
//   where valid and ready are both high. While out_valid is high, out_sum and
//   out_sat do not change. in_ready may depend combinationally on out_ready
//   (in HOLD) and on rst; it never depends on in_valid.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pparch_hancarlson16
//   16-bit Han-Carlson parallel-prefix adder.
//   Ports: a, b (16-bit operands), cin (carry in), sum (16-bit result).
//   Odd bit positions run a Kogge-Stone tree (spans 2, 4, 8) after an initial
//   pairing step; even positions pick up their carry in one final step from
//   the odd neighbour below.
// ---------------------------------------------------------------------------
module pparch_hancarlson16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum
);

   always_comb begin
      logic [15:0] p;
      logic [15:0] g;
      logic [15:0] gg;
      logic [15:0] pp;
      logic [15:0] gn;
      logic [15:0] pn;
      logic [15:0] c;
      int          d;

      p = a ^ b;
      g = a & b;
      // Fold the carry-in into bit 0 so the tree sees a plain generate.
      g[0] = g[0] | (p[0] & cin);

      gg = g;
      pp = p;

      // Pair each odd bit with its even neighbour below.
      for (int i = 1; i < 16; i += 2) begin
         gg[i] = g[i] | (p[i] & g[i-1]);
         pp[i] = p[i] & p[i-1];
      end

      // Kogge-Stone over the odd positions only.
      for (int s = 1; s < 4; s++) begin
         d  = 1 << s;
         gn = gg;
         pn = pp;
         for (int i = 1; i < 16; i += 2) begin
            if (i - d >= 0) begin
               gn[i] = gg[i] | (pp[i] & gg[i-d]);
               pn[i] = pp[i] & pp[i-d];
            end
         end
         gg = gn;
         pp = pn;
      end

      // Even positions: combine with the finished odd prefix just below.
      for (int i = 2; i < 16; i += 2) begin
         gg[i] = g[i] | (p[i] & gg[i-1]);
      end

      // gg[i] is now the carry out of bit i.
      c       = {gg[14:0], cin};
      sum     = p ^ c;
   end

endmodule

module fir_tap_accumulator #(
   parameter int N_TAPS = 8,
   parameter int CNT_W  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic        out_sat
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [15:0]        acc;

   logic [15:0]        a_op;
   logic [15:0]        add_sum;
   logic [15:0]        next_acc;
   logic               accept;
   logic               last_term;
   logic               ovf;

   // The first term of a sample starts from zero rather than the old sum.
   assign a_op      = (cnt == '0) ? 16'h0000 : acc;
   assign last_term = (cnt == CNT_W'(N_TAPS - 1));

   // In HOLD the register is occupied; it can take a new term only in the
   // cycle the held sample leaves.
   assign in_ready  = ~rst & ((state == ACC) | out_ready);
   assign accept    = in_valid & in_ready;

   pparch_hancarlson16 u_adder (
      .a   (a_op),
      .b   (in_data),
      .cin (1'b0),
      .sum (add_sum)
   );

`ifdef FIR_ACC_SAT_EN
   logic sat_acc;

   // Signed overflow: operands agree in sign, result disagrees.
   assign ovf      = (a_op[15] == in_data[15]) && (add_sum[15] != a_op[15]);
   assign next_acc = ovf ? (a_op[15] ? 16'h8000 : 16'h7FFF) : add_sum;
`else
   assign ovf      = 1'b0;
   assign next_acc = add_sum;
   assign out_sat  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACC;
         cnt       <= '0;
         acc       <= 16'h0000;
         out_valid <= 1'b0;
         out_sum   <= 16'h0000;
`ifdef FIR_ACC_SAT_EN
         sat_acc   <= 1'b0;
         out_sat   <= 1'b0;
`endif
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  acc <= next_acc;
`ifdef FIR_ACC_SAT_EN
                  // First term of a sample clears the sticky flag.
                  sat_acc <= (cnt == '0) ? ovf : (sat_acc | ovf);
`endif
                  if (last_term) begin
                     out_sum   <= next_acc;
                     out_valid <= 1'b1;
                     cnt       <= '0;
                     state     <= HOLD;
`ifdef FIR_ACC_SAT_EN
                     out_sat   <= sat_acc | ovf;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACC;
                  // cnt is 0 here, so the adder passes in_data straight through.
                  if (in_valid) begin
                     acc <= next_acc;
                     cnt <= CNT_W'(1);
`ifdef FIR_ACC_SAT_EN
                     sat_acc <= ovf;
`endif
                  end
               end
            end
            default: begin
               state <= ACC;
            end
         endcase
      end
   end

endmodule
